// File: rtl/board_pkg.sv
// Shared constants and helpers for the board hole-count evaluator.
package board_pkg;

  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int BOARD_W = ROWS * COLS;
  localparam int CNT_W   = 5;
  localparam int SCORE_W = 32;
  // Wide enough for COLS*(ROWS-1) = 190.
  localparam int SUM_W   = 8;

  // Flat bit position of cell (r,c); row 0 is the top row.
  function automatic int cell_index(input int r, input int c);
    return COLS * r + c;
  endfunction

endpackage

// File: rtl/board_analysis_column_hole_counter.sv
// Combinational hole count for one board column (index 0 = top row).
module column_hole_counter
  import board_pkg::*;
(
  input  logic [ROWS-1:0]  col,
  output logic [CNT_W-1:0] cnt
);

  logic seen_filled;

  // Scan top to bottom; every empty cell below the first filled one is a hole.
  always_comb begin
    seen_filled = 1'b0;
    cnt         = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (col[r]) begin
        seen_filled = 1'b1;
      end else if (seen_filled) begin
        cnt = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/board_analysis.sv
// Two-stage pipelined hole-count scorer for a ROWS x COLS board snapshot.
// Stage 1 registers per-column counts, stage 2 registers their sum.
module board_analysis
  import board_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BOARD_W-1:0] board,
  output logic [SCORE_W-1:0] score
);

  logic [COLS-1:0][ROWS-1:0] col_bits;
  logic [CNT_W-1:0]          cnt_d [COLS];
  logic [CNT_W-1:0]          cnt_q [COLS];
  logic [SCORE_W-1:0]        score_d;
  logic [SCORE_W-1:0]        score_q;
  logic [SUM_W-1:0]          sum;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign col_bits[c][r] = board[cell_index(r, c)];
    end

    column_hole_counter u_col_cnt (
      .col (col_bits[c]),
      .cnt (cnt_d[c])
    );
  end

  // Add the registered column counts; 8 bits cannot overflow at 190.
  always_comb begin
    sum = '0;
    for (int c = 0; c < COLS; c++) begin
      sum = sum + SUM_W'(cnt_q[c]);
    end
    score_d = SCORE_W'(sum);
  end

  // Pipeline registers; reset clears every stage so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        cnt_q[c] <= '0;
      end
      score_q <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: tb/tb_board_analysis.sv
// Directed-vector bench for board_analysis with hand-computed hole counts.
module tb_board_analysis;

  localparam int BW = 200;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] board;
  logic [31:0]   score;

  int n_tests;
  int n_fail;

  board_analysis dut (
    .clk   (clk),
    .rst_n (rst_n),
    .board (board),
    .score (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a board for two edges, then compare the score.
  task automatic run_board(input string tag, input logic [BW-1:0] b, input int exp);
    board = b;
    tick();
    tick();
    check(tag, score, 32'(exp));
  endtask

  logic [BW-1:0] row0;
  logic [BW-1:0] row19;
  logic [BW-1:0] vec [5];
  int            vexp [5];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    board   = '1;
    row0    = 200'h3FF;
    row19   = row0 << 190;

    repeat (3) tick();
    check("reset_hold", score, 32'd0);
    rst_n = 1'b1;

    run_board("all_zero",      '0,                                  0);
    run_board("all_ones",      '1,                                  0);
    run_board("row0_full",     row0,                                190);
    run_board("cell_r5_c3",    200'd1 << 53,                        14);
    run_board("cell_r19_c0",   200'd1 << 190,                       0);
    run_board("row0_row19",    row0 | row19,                        180);
    run_board("c3_r2_r10",     (200'd1 << 23) | (200'd1 << 103),    16);

    // Pipeline: A applied, then B one cycle later.
    board = '1;
    tick();
    tick();
    board = 200'd1;
    tick();
    check("pipe_prev", score, 32'd0);
    board = '0;
    tick();
    check("pipe_a", score, 32'd19);
    tick();
    check("pipe_b", score, 32'd0);

    // Back-to-back boards, each expected two edges after it is sampled.
    vec[0] = row0;          vexp[0] = 190;
    vec[1] = 200'd1 << 53;  vexp[1] = 14;
    vec[2] = '1;            vexp[2] = 0;
    vec[3] = 200'd1 << 9;   vexp[3] = 19;
    vec[4] = row0 | row19;  vexp[4] = 180;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) board = vec[i];
      tick();
      if (i >= 1) check($sformatf("stream_%0d", i - 1), score, 32'(vexp[i - 1]));
    end

    // Mid-operation reset with the board held.
    run_board("pre_reset", row0, 190);
    rst_n = 1'b0;
    tick();
    check("reset_mid", score, 32'd0);
    rst_n = 1'b1;
    tick();
    check("release_1", score, 32'd0);
    tick();
    check("release_2", score, 32'd190);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
